// File: rtl/gpu_bram_lanes.sv
// Simple-dual-port lane-masked block RAM with selectable read-during-write policy,
// optional output register and a hardware clear sequencer for wiping buffers between frames.
module gpu_bram_lanes #(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int LANES = 4,
  parameter bit BYPASS = 1'b1,
  parameter bit OUT_REG = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] mem_dout_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  mem_dout_valid,
  input  logic                  we,
  input  logic [LANES-1:0]      we_mask,
  input  logic [ADDR_WIDTH-1:0] mem_din_addr,
  input  logic [DATA_WIDTH-1:0] mem_din
);

  localparam int LW = DATA_WIDTH / LANES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_mask;
  logic                  wr_in_range, rd_in_range, rd_fire, hit;

  logic                  v1_q, v1_d;
  logic [DATA_WIDTH-1:0] ram_q, ram_d;
  logic                  hit_q, hit_d;
  logic [LANES-1:0]      hmask_q, hmask_d;
  logic [DATA_WIDTH-1:0] hdata_q, hdata_d;
  logic [DATA_WIDTH-1:0] dout1;

  assign ready       = (state_q == RUN);
  assign wr_in_range = ({1'b0, mem_din_addr} < SIZE_W);
  assign rd_in_range = ({1'b0, mem_dout_addr} < SIZE_W);
  assign rd_fire     = re & ready;
  assign hit         = BYPASS & rd_fire & we & wr_in_range & (mem_din_addr == mem_dout_addr);

  // The sequencer owns the write port while clearing; user traffic only reaches it in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = mem_din_addr;
    wr_data = mem_din;
    wr_mask = we_mask;
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = CLEAR_VALUE;
        wr_mask = '1;
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) state_d = RUN;
      end
      default: begin
        wr_en = we & wr_in_range;
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
      end
    end
  end

  // The array is read-first; write-first behaviour comes from merging the captured write afterwards.
  always_comb begin
    v1_d    = rd_fire;
    ram_d   = ram_q;
    hit_d   = hit_q;
    hmask_d = hmask_q;
    hdata_d = hdata_q;
    if (rd_fire) begin
      ram_d   = rd_in_range ? mem[mem_dout_addr] : '0;
      hit_d   = hit;
      hmask_d = we_mask;
      hdata_d = mem_din;
    end
  end

  always_comb begin
    dout1 = ram_q;
    for (int i = 0; i < LANES; i++) begin
      if (hit_q && hmask_q[i]) dout1[i*LW +: LW] = hdata_q[i*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      ram_q   <= '0;
      hit_q   <= 1'b0;
      hmask_q <= '0;
      hdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      ram_q   <= ram_d;
      hit_q   <= hit_d;
      hmask_q <= hmask_d;
      hdata_q <= hdata_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic                  v2_q, v2_d;
    logic [DATA_WIDTH-1:0] dout2_q, dout2_d;

    always_comb begin
      v2_d    = v1_q;
      dout2_d = v1_q ? dout1 : dout2_q;
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        v2_q    <= 1'b0;
        dout2_q <= '0;
      end else begin
        v2_q    <= v2_d;
        dout2_q <= dout2_d;
      end
    end

    assign mem_dout       = dout2_q;
    assign mem_dout_valid = v2_q;
  end else begin : g_no_out_reg
    assign mem_dout       = dout1;
    assign mem_dout_valid = v1_q;
  end

endmodule
